// File: rtl/ex_stage_reg.sv
// Execute stage: operand forwarding, ALU, branch-target add,
// and the EX/MEM pipeline latch with stall/flush control.
module ex_stage_reg #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [3:0]          operation,
    input  logic                alu_src,
    input  logic                reg_write_in,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic                mem_to_reg_in,
    input  logic                branch_in,
    input  logic [WIDTH-1:0]    pc_plus4,
    input  logic [WIDTH-1:0]    rs_data,
    input  logic [WIDTH-1:0]    rt_data,
    input  logic [WIDTH-1:0]    imm_ext,
    input  logic [REG_BITS-1:0] write_reg_in,
    input  logic [1:0]          fwd_a,
    input  logic [1:0]          fwd_b,
    input  logic [WIDTH-1:0]    ex_mem_fwd_data,
    input  logic [WIDTH-1:0]    mem_wb_fwd_data,
    output logic                ex_mem_valid,
    output logic [WIDTH-1:0]    ex_mem_alu_result,
    output logic                ex_mem_zero,
    output logic [WIDTH-1:0]    ex_mem_branch_target,
    output logic [WIDTH-1:0]    ex_mem_store_data,
    output logic [REG_BITS-1:0] ex_mem_write_reg,
    output logic                ex_mem_reg_write,
    output logic                ex_mem_mem_read,
    output logic                ex_mem_mem_write,
    output logic                ex_mem_mem_to_reg,
    output logic                ex_mem_branch
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] fwd_b_data;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] target;
    logic             slt_bit;

    // Select code 11 is unused and falls back to the register file.
    always_comb begin
        op_a = rs_data;
        case (fwd_a)
            2'b01:   op_a = mem_wb_fwd_data;
            2'b10:   op_a = ex_mem_fwd_data;
            default: op_a = rs_data;
        endcase
    end

    always_comb begin
        fwd_b_data = rt_data;
        case (fwd_b)
            2'b01:   fwd_b_data = mem_wb_fwd_data;
            2'b10:   fwd_b_data = ex_mem_fwd_data;
            default: fwd_b_data = rt_data;
        endcase
    end

    assign op_b    = alu_src ? imm_ext : fwd_b_data;
    assign slt_bit = $signed(op_a) < $signed(op_b);
    assign target  = pc_plus4 + (imm_ext << 2);

    always_comb begin
        result = '0;
        case (operation)
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_ADD:  result = op_a + op_b;
            OP_SUB:  result = op_a - op_b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
            default: result = '0;
        endcase
    end

    // A bubble (in_valid low) clears the latch just like flush.
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !in_valid)) begin
            ex_mem_valid         <= 1'b0;
            ex_mem_alu_result    <= '0;
            ex_mem_zero          <= 1'b0;
            ex_mem_branch_target <= '0;
            ex_mem_store_data    <= '0;
            ex_mem_write_reg     <= '0;
            ex_mem_reg_write     <= 1'b0;
            ex_mem_mem_read      <= 1'b0;
            ex_mem_mem_write     <= 1'b0;
            ex_mem_mem_to_reg    <= 1'b0;
            ex_mem_branch        <= 1'b0;
        end else if (!stall) begin
            ex_mem_valid         <= 1'b1;
            ex_mem_alu_result    <= result;
            ex_mem_zero          <= (result == '0);
            ex_mem_branch_target <= target;
            ex_mem_store_data    <= fwd_b_data;
            ex_mem_write_reg     <= write_reg_in;
            ex_mem_reg_write     <= reg_write_in;
            ex_mem_mem_read      <= mem_read_in;
            ex_mem_mem_write     <= mem_write_in;
            ex_mem_mem_to_reg    <= mem_to_reg_in;
            ex_mem_branch        <= branch_in;
        end
    end

endmodule

// File: doc/ex_stage_reg.md
Name: ex_stage_reg

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the 4-bit ALU operation code produced by ALU control, together with ID/EX operands and controls.
- Resolves forwarding, performs the ALU function and branch-target add, and registers the result into the EX/MEM pipeline latch with stall/flush control.
- Result is visible one cycle after the operands are presented.

Parameters:
- WIDTH, 32, datapath width in bits.
- REG_BITS, 5, register-index width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold the EX/MEM latch contents
- flush  in  1  load a bubble into the EX/MEM latch
- in_valid  in  1  ID/EX holds a real instruction
- operation  in  4  ALU op: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1111 nop
- alu_src  in  1  1 = operand B is imm_ext
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in  in  1 each  ID/EX control bits
- pc_plus4  in  WIDTH  PC+4 of the instruction
- rs_data, rt_data  in  WIDTH  register-file read data
- imm_ext  in  WIDTH  sign-extended immediate
- write_reg_in  in  REG_BITS  destination register
- fwd_a, fwd_b  in  2  00 = register file, 01 = MEM/WB, 10 = EX/MEM, 11 = treated as 00
- ex_mem_fwd_data, mem_wb_fwd_data  in  WIDTH  forwarding sources
- ex_mem_valid  out  1  latched valid
- ex_mem_alu_result  out  WIDTH  latched ALU result
- ex_mem_zero  out  1  latched zero flag
- ex_mem_branch_target  out  WIDTH  latched branch target
- ex_mem_store_data  out  WIDTH  latched store data
- ex_mem_write_reg  out  REG_BITS  latched destination register
- ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg, ex_mem_branch  out  1 each  latched control bits

Behaviour:
- Operand select (combinational):
  - A = mux(fwd_a) over rs_data.
  - Fb = mux(fwd_b) over rt_data.
  - B = alu_src ? imm_ext : Fb.
  - Store data = Fb, never imm_ext.
- ALU (combinational):
  - and/or are bitwise.
  - add and sub wrap modulo 2^WIDTH; overflow is ignored, no exception.
  - slt is a signed two's-complement compare: result 1 if A<B, else 0, zero-extended.
  - 1111 and every undefined code give result 0.
  - zero = (result == 0).
- Branch target: pc_plus4 + (imm_ext << 2), wraps modulo 2^WIDTH.
- EX/MEM latch update on each rising clk edge, priority rst > flush > stall > load:
  - rst: every output is 0.
  - flush: every output is 0, same as rst. flush beats stall when both are asserted.
  - stall (no rst/flush): every output holds its value.
  - load with in_valid=1: all outputs take the computed values and input controls; ex_mem_valid=1.
  - load with in_valid=0: bubble, all outputs 0.
- Latency is exactly 1 cycle from operands to outputs, with no internal buffering beyond one entry.
- Reset mid-stream discards the latched instruction. The first load after rst deasserts captures that cycle's inputs.
- Forwarding data is sampled in the same cycle it is selected; there are no combinational paths from outputs to inputs inside the block.
- Control outputs are never 1 while ex_mem_valid=0.

Test Plan:
- rst=1 for 2 cycles with random inputs -> all outputs 0; after release, add 5+7 (operation=0010, in_valid=1) -> next cycle ex_mem_alu_result=12, zero=0, valid=1.
- sub rs=rt=0x1234 (0110) -> result 0, zero=1. slt A=0xFFFFFFFF, B=1 -> result 1. slt A=1, B=0xFFFFFFFF -> result 0. add 0xFFFFFFFF+1 -> 0, zero=1.
- fwd_a=10 with ex_mem_fwd_data=100; fwd_b=01 with mem_wb_fwd_data=3; alu_src=0, op add -> 103. Repeat with fwd_a=11 -> uses rs_data. alu_src=1, imm_ext=8, fwd_b=01, mem_write_in=1 -> result A+8, store_data=3, ex_mem_mem_write=1.
- Branch: pc_plus4=0x100, imm_ext=0xFFFFFFFF -> branch_target=0xFC. pc_plus4=0xFFFFFFFC, imm_ext=1 -> 0x0 (wrap).
- Load instruction X; then stall=1 for 3 cycles with new inputs -> outputs stay X. Then stall=1 and flush=1 together -> all outputs 0 next cycle.
- in_valid=0 with reg_write_in=1 -> ex_mem_reg_write=0, valid=0. operation=1111 and 0101 -> result 0, zero=1.
